// File: rtl/orpsoc_wb_pkg.sv
// Shared Wishbone definitions for the ORPSoC bus fabric: cycle-type/burst
// encodings, default bus widths and the arbiter state type.
package orpsoc_wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } wb_cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } wb_bte_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Width of a master index; never zero, even for a single master.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of packed master requests/responses, the shared slave port and the
// grant vector. slave = arbiter view, master = view of the surrounding fabric.
interface wb_rr_arbiter_if
  import orpsoc_wb_pkg::*;
#(
  parameter int NUM_M = 3,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) ();

  logic [NUM_M-1:0][AW-1:0]   m_adr_i;
  logic [NUM_M-1:0][DW-1:0]   m_dat_i;
  logic [NUM_M-1:0][DW/8-1:0] m_sel_i;
  logic [NUM_M-1:0]           m_we_i;
  logic [NUM_M-1:0]           m_cyc_i;
  logic [NUM_M-1:0]           m_stb_i;
  logic [NUM_M-1:0][2:0]      m_cti_i;
  logic [NUM_M-1:0][1:0]      m_bte_i;

  logic [NUM_M-1:0][DW-1:0]   m_dat_o;
  logic [NUM_M-1:0]           m_ack_o;
  logic [NUM_M-1:0]           m_err_o;
  logic [NUM_M-1:0]           m_rty_o;

  logic [AW-1:0]              s_adr_o;
  logic [DW-1:0]              s_dat_o;
  logic [DW/8-1:0]            s_sel_o;
  logic                       s_we_o;
  logic                       s_cyc_o;
  logic                       s_stb_o;
  logic [2:0]                 s_cti_o;
  logic [1:0]                 s_bte_o;

  logic [DW-1:0]              s_dat_i;
  logic                       s_ack_i;
  logic                       s_err_i;
  logic                       s_rty_i;

  logic [NUM_M-1:0]           grant_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output grant_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  grant_o
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester found scanning upward
// from last_i+1 (modulo NUM_M) wins.
module rr_pick
  import orpsoc_wb_pkg::*;
#(
  parameter int NUM_M = 3,
  parameter int IW    = idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  logic [IW-1:0] cand;

  // Scan farthest-first so the nearest requester after last_i overwrites.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      cand = IW'((int'(last_i) + k) % NUM_M);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave port, with a
// response watchdog that errors the owner when the slave goes silent.
//
//   state     | meaning
//   ARB_IDLE  | no owner; any m_cyc_i is arbitrated at the next edge
//   ARB_OWNED | one master owns the slave port until it drops m_cyc_i
module wb_rr_arbiter
  import orpsoc_wb_pkg::*;
#(
  parameter int NUM_M   = 3,
  parameter int DW      = WB_DW,
  parameter int AW      = WB_AW,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  wb_rr_arbiter_if.slave   bus
);

  localparam int              IW       = idx_w(NUM_M);
  localparam logic [9:0]      TO_C     = 10'(TIMEOUT);
  localparam logic [IW-1:0]   LAST_RST = IW'(NUM_M - 1);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [9:0]       wdog_q, wdog_d;

  logic [NUM_M-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             owned, own_cyc, stb_raw, wdog_fire, s_resp;

  logic [AW-1:0]    adr_mux;
  logic [DW-1:0]    dat_mux;
  logic [DW/8-1:0]  sel_mux;

  rr_pick #(.NUM_M(NUM_M), .IW(IW)) u_pick (
    .req_i  (bus.m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign owned     = (state_q == ARB_OWNED);
  assign own_cyc   = bus.m_cyc_i[owner_q];
  assign stb_raw   = owned & own_cyc & bus.m_stb_i[owner_q];
  assign wdog_fire = owned && (wdog_q == TO_C);
  assign s_resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d = ARB_OWNED;
          grant_d = pick_gnt;
          owner_d = pick_idx;
        end
      end
      ARB_OWNED: begin
        if (!own_cyc) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
    endcase
    // Counts consecutive strobed cycles with no slave response.
    wdog_d = (wdog_fire || s_resp || !stb_raw) ? 10'd0 : wdog_q + 10'd1;
  end

  assign adr_mux     = bus.m_adr_i[owner_q];
  assign dat_mux     = bus.m_dat_i[owner_q];
  assign sel_mux     = bus.m_sel_i[owner_q];

  assign bus.s_adr_o = adr_mux;
  assign bus.s_dat_o = dat_mux;
  assign bus.s_sel_o = sel_mux;
  assign bus.s_we_o  = bus.m_we_i[owner_q];
  assign bus.s_cti_o = bus.m_cti_i[owner_q];
  assign bus.s_bte_o = bus.m_bte_i[owner_q];
  assign bus.s_cyc_o = owned & own_cyc;
  assign bus.s_stb_o = stb_raw & ~wdog_fire;

  // grant_q is zero outside ARB_OWNED, so responses only ever reach the owner,
  // including an ack arriving in the cycle the owner drops cyc.
  assign bus.m_dat_o = {NUM_M{bus.s_dat_i}};
  assign bus.m_ack_o = grant_q & {NUM_M{bus.s_ack_i}};
  assign bus.m_err_o = grant_q & {NUM_M{bus.s_err_i | wdog_fire}};
  assign bus.m_rty_o = grant_q & {NUM_M{bus.s_rty_i}};
  assign bus.grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: stimulus pushes expected grants/responses
// into queues, a negedge monitor pops and compares them.
module tb_wb_rr_arbiter;
  import orpsoc_wb_pkg::*;

  localparam int NM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NUM_M(NM), .AW(32), .DW(32)) bus ();

  wb_rr_arbiter #(.NUM_M(NM), .DW(32), .AW(32), .TIMEOUT(8)) u_dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  // Slave: zero-wait ack while enabled, plus a manual ack override.
  logic ack_en = 1'b0;
  logic force_ack = 1'b0;
  assign bus.s_ack_i = (ack_en & bus.s_cyc_o & bus.s_stb_o) | force_ack;

  int errors = 0;
  int checks = 0;

  // Master model: ncyc cycles of blen beats each; cyc drops one cycle between cycles.
  int ncyc[NM];
  int blen[NM];
  int beat[NM];
  bit burst[NM];
  bit dropped[NM];

  typedef struct { logic [2:0] gnt; int gap; } gexp_t;
  typedef struct { logic [2:0] ack; logic [2:0] err; bit tmo; int run; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t ge;
  rexp_t re;
  logic [2:0] prev_gnt = '0;
  int gap = 0;
  int stb_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic eg(input logic [2:0] g);
    gexp_t t;
    t.gnt = g;
    t.gap = 1;
    gq.push_back(t);
  endtask

  task automatic ea(input logic [2:0] a);
    rexp_t t;
    t.ack = a; t.err = 3'b000; t.tmo = 1'b0; t.run = 0;
    rq.push_back(t);
  endtask

  task automatic ee(input logic [2:0] v, input int run);
    rexp_t t;
    t.ack = 3'b000; t.err = v; t.tmo = 1'b1; t.run = run;
    rq.push_back(t);
  endtask

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      bus.m_cyc_i[i] = (ncyc[i] > 0) && !dropped[i];
      bus.m_stb_i[i] = (ncyc[i] > 0) && !dropped[i];
      bus.m_cti_i[i] = !burst[i] ? CTI_CLASSIC : (beat[i] == blen[i] - 1) ? CTI_EOB : CTI_INCR;
      bus.m_bte_i[i] = BTE_LINEAR;
      bus.m_adr_i[i] = 32'h1000 + 32'(i) * 32'h100 + 32'(beat[i]) * 32'd4;
      bus.m_dat_i[i] = 32'hA000_0000 + 32'(i);
      bus.m_sel_i[i] = 4'hF;
      bus.m_we_i[i]  = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NM; i++) begin
      if (ncyc[i] > 0 && (bus.m_ack_o[i] || bus.m_err_o[i])) begin
        beat[i]++;
        if (beat[i] == blen[i]) begin
          beat[i] = 0;
          ncyc[i]--;
          dropped[i] = 1'b1;
        end
      end else begin
        dropped[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit busy();
    for (int i = 0; i < NM; i++)
      if (ncyc[i] > 0) return 1'b1;
    return bus.grant_o != 3'b000;
  endfunction

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL run_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NM; i++) begin
      ncyc[i] = 0; blen[i] = 1; beat[i] = 0; burst[i] = 1'b0; dropped[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
      gap      = 0;
      stb_run  = 0;
    end else begin
      if (bus.grant_o != 3'b000 && prev_gnt == 3'b000) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant: got unexpected %b, required none", bus.grant_o);
        end else begin
          ge = gq.pop_front();
          check("grant", 32'(bus.grant_o), 32'(ge.gnt));
          check("grant_gap", 32'(gap), 32'(ge.gap));
        end
        gap = 0;
      end else if (bus.grant_o == 3'b000) begin
        gap = (|bus.m_cyc_i) ? gap + 1 : 0;
      end
      if (|{bus.m_ack_o, bus.m_err_o, bus.m_rty_o}) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp: got unexpected ack=%b err=%b rty=%b, required none",
                   bus.m_ack_o, bus.m_err_o, bus.m_rty_o);
        end else begin
          re = rq.pop_front();
          check("ack", 32'(bus.m_ack_o), 32'(re.ack));
          check("err", 32'(bus.m_err_o), 32'(re.err));
          check("rty", 32'(bus.m_rty_o), 32'd0);
          if (re.tmo) begin
            check("tmo_stb", 32'(bus.s_stb_o), 32'd0);
            check("tmo_delay", 32'(stb_run), 32'(re.run));
          end
        end
      end
      stb_run  = bus.s_stb_o ? stb_run + 1 : 0;
      prev_gnt = bus.grant_o;
    end
  end

  initial begin
    clear_model();
    drive();
    bus.s_dat_i = 32'hCAFE_0000;
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state with masters 0 and 2 already requesting.
    ack_en  = 1'b1;
    ncyc[0] = 1;
    ncyc[2] = 1;
    drive();
    #2;
    check("rst_grant", 32'(bus.grant_o), 32'd0);
    check("rst_cyc", 32'(bus.s_cyc_o), 32'd0);
    check("rst_stb", 32'(bus.s_stb_o), 32'd0);
    check("rst_resp", 32'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 32'd0);
    eg(3'b001); eg(3'b100);
    ea(3'b001); ea(3'b100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    check("lat_cyc_n", 32'(bus.s_cyc_o), 32'd0);
    step();
    #2;
    check("lat_cyc_n1", 32'(bus.s_cyc_o), 32'd1);
    check("mux_adr", bus.s_adr_o, 32'h1000);
    run_idle(50);

    // All three masters, two single-beat cycles each: strict rotation.
    for (int i = 0; i < NM; i++) ncyc[i] = 2;
    for (int r = 0; r < 2; r++) begin
      eg(3'b001); eg(3'b010); eg(3'b100);
      ea(3'b001); ea(3'b010); ea(3'b100);
    end
    drive();
    run_idle(200);

    // Master 1 four-beat burst while master 0 waits.
    ncyc[1] = 1; blen[1] = 4; burst[1] = 1'b1;
    eg(3'b010); eg(3'b001);
    ea(3'b010); ea(3'b010); ea(3'b010); ea(3'b010); ea(3'b001);
    drive();
    step();
    ncyc[0] = 1;
    drive();
    #2;
    check("burst_cti", 32'(bus.s_cti_o), 32'(CTI_INCR));
    run_idle(100);
    clear_model();

    // Silent slave: watchdog error to master 2 after 8 strobed cycles.
    ack_en  = 1'b0;
    ncyc[2] = 1;
    eg(3'b100);
    ee(3'b100, 8);
    drive();
    run_idle(100);

    // Master 0 single cycle so the pointer sits at 0 before the reset test.
    ack_en  = 1'b1;
    ncyc[0] = 1;
    eg(3'b001);
    ea(3'b001);
    drive();
    run_idle(50);

    // Reset mid-burst of master 2; afterwards master 0 must win over master 1.
    ack_en  = 1'b0;
    ncyc[2] = 1; blen[2] = 4; burst[2] = 1'b1;
    eg(3'b100);
    drive();
    step();
    step();
    #1;
    check("pre_rst_cyc", 32'(bus.s_cyc_o), 32'd1);
    check("pre_rst_grant", 32'(bus.grant_o), 32'b100);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(bus.grant_o), 32'd0);
    check("async_cyc", 32'(bus.s_cyc_o), 32'd0);
    check("async_stb", 32'(bus.s_stb_o), 32'd0);
    clear_model();
    ncyc[0] = 1;
    ncyc[1] = 1;
    ack_en  = 1'b1;
    drive();
    eg(3'b001); eg(3'b010);
    ea(3'b001); ea(3'b010);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_idle(100);

    // Master 2 drops cyc in the same cycle the slave acks.
    ack_en  = 1'b0;
    ncyc[2] = 1;
    eg(3'b100);
    ea(3'b100);
    drive();
    step();
    ncyc[2]   = 0;
    force_ack = 1'b1;
    drive();
    step();
    force_ack = 1'b0;
    #2;
    check("idle_after_drop", 32'(bus.grant_o), 32'd0);
    // Pointer now at 2: master 1 must beat master 2.
    ack_en  = 1'b1;
    ncyc[1] = 1;
    ncyc[2] = 1;
    eg(3'b010); eg(3'b100);
    ea(3'b010); ea(3'b100);
    drive();
    run_idle(100);

    repeat (3) @(posedge clk);
    #1;
    check("grant_queue_empty", 32'(gq.size()), 32'd0);
    check("resp_queue_empty", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
